// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider / strobe generator with glitch-free divisor updates.
// Optional phase-align input `sync` is built only when CLK_DIV_SYNC_EN is defined.
module clk_div_prog #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 10,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef CLK_DIV_SYNC_EN
    input  logic              sync,
`endif
    input  logic [NUM_CH-1:0] en,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [CNT_W-1:0]  div_val,
    output logic              div_rdy,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CNT_W-1:0] DEF_D   = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);

    logic [CNT_W-1:0] div_q    [NUM_CH];
    logic [CNT_W-1:0] cnt_q    [NUM_CH];
    logic [CNT_W-1:0] shadow_q [NUM_CH];
    logic [CNT_W-1:0] div_nx   [NUM_CH];
    logic [CNT_W-1:0] cnt_nx   [NUM_CH];
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] apply;
    logic [NUM_CH-1:0] accept;
    logic [CNT_W-1:0]  wr_val;
    logic              sync_req;

`ifdef CLK_DIV_SYNC_EN
    assign sync_req = sync;
`else
    assign sync_req = 1'b0;
`endif

    assign wr_val = (div_val < MIN_DIV) ? MIN_DIV : div_val;

    // Channel match by loop keeps out-of-range div_ch from indexing pending.
    always_comb begin
        div_rdy = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (div_ch == CH_W'(i)) div_rdy = !pending[i];
        end
    end

    always_comb begin
        wrap   = '0;
        apply  = '0;
        accept = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wrap[i]   = (cnt_q[i] == div_q[i] - ONE) || sync_req;
            apply[i]  = en[i] && wrap[i] && pending[i];
            div_nx[i] = apply[i] ? shadow_q[i] : div_q[i];
            cnt_nx[i] = wrap[i] ? '0 : cnt_q[i] + ONE;
            accept[i] = div_wr && div_rdy && (div_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                div_q[i]    <= DEF_D;
                cnt_q[i]    <= DEF_D - ONE;
                shadow_q[i] <= '0;
            end
            pending <= '0;
            clk_out <= '0;
            tick    <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (en[i]) begin
                    cnt_q[i]   <= cnt_nx[i];
                    div_q[i]   <= div_nx[i];
                    clk_out[i] <= cnt_nx[i] < (div_nx[i] >> 1);
                    tick[i]    <= cnt_nx[i] == '0;
                end else begin
                    tick[i] <= 1'b0;
                end
                // accept requires !pending, so it never collides with apply
                if (apply[i]) pending[i] <= 1'b0;
                if (accept[i]) begin
                    shadow_q[i] <= wr_val;
                    pending[i]  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: period-position model plus directed literal checks.
// Sync scenario is compiled only with CLK_DIV_SYNC_EN defined.
module tb_clk_div_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       sync;
    logic [2:0] en_a;
    logic       div_wr;
    logic [1:0] div_ch;
    logic [7:0] div_val;
    logic       div_rdy_a;
    logic [2:0] pending_a, clk_out_a, tick_a;
    logic       en_b;
    logic       div_rdy_b;
    logic [0:0] pending_b, clk_out_b, tick_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    clk_div_prog #(.NUM_CH(3), .CNT_W(8), .DEF_DIV(4)) dut_a (
        .clk(clk), .rst(rst),
`ifdef CLK_DIV_SYNC_EN
        .sync(sync),
`endif
        .en(en_a), .div_wr(div_wr), .div_ch(div_ch), .div_val(div_val),
        .div_rdy(div_rdy_a), .pending(pending_a), .clk_out(clk_out_a), .tick(tick_a)
    );

    clk_div_prog #(.NUM_CH(1), .CNT_W(8), .DEF_DIV(5)) dut_b (
        .clk(clk), .rst(rst),
`ifdef CLK_DIV_SYNC_EN
        .sync(1'b0),
`endif
        .en(en_b), .div_wr(1'b0), .div_ch(1'b0), .div_val(8'd0),
        .div_rdy(div_rdy_b), .pending(pending_b), .clk_out(clk_out_b), .tick(tick_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: channels 0..2 belong to dut_a, channel 3 is dut_b.
    // pos = enabled edges since the current period began; reset leaves it on the last slot.
    int m_d[4], m_pos[4], m_sh[4];
    bit m_pend[4], m_clk[4], m_tick[4];
    bit armed = 0;

    function automatic int def_div(input int c);
        return (c < 3) ? 4 : 5;
    endfunction

    always @(posedge clk) begin
        bit acc;
        bit e;
        int wch;
        logic [2:0] ec, et, ep;
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                m_d[c] = def_div(c); m_pos[c] = m_d[c] - 1; m_sh[c] = 0;
                m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
            end
            armed = 1;
        end else if (armed) begin
            wch = int'(div_ch);
            acc = div_wr && (wch < 3) && !m_pend[(wch < 3) ? wch : 0];
            for (int c = 0; c < 4; c++) begin
                e = (c < 3) ? en_a[c] : en_b;
                if (e) begin
                    if (m_pos[c] == m_d[c] - 1 || (sync && c < 3)) begin
                        if (m_pend[c]) begin m_d[c] = m_sh[c]; m_pend[c] = 0; end
                        m_pos[c] = 0;
                    end else begin
                        m_pos[c]++;
                    end
                    m_clk[c]  = m_pos[c] < m_d[c] / 2;
                    m_tick[c] = m_pos[c] == 0;
                end else begin
                    m_tick[c] = 0;
                end
            end
            if (acc) begin
                m_sh[wch]   = (div_val < 2) ? 2 : int'(div_val);
                m_pend[wch] = 1;
            end
        end
        #1;
        if (armed) begin
            for (int c = 0; c < 3; c++) begin
                ec[c] = m_clk[c]; et[c] = m_tick[c]; ep[c] = m_pend[c];
            end
            chk("model clk_out_a", 32'(clk_out_a), 32'(ec));
            chk("model tick_a", 32'(tick_a), 32'(et));
            chk("model pending_a", 32'(pending_a), 32'(ep));
            chk("model div_rdy_a", 32'(div_rdy_a),
                32'((int'(div_ch) < 3) && !m_pend[(int'(div_ch) < 3) ? int'(div_ch) : 0]));
            chk("model clk_out_b", 32'(clk_out_b), 32'(m_clk[3]));
            chk("model tick_b", 32'(tick_b), 32'(m_tick[3]));
            chk("model pending_b", 32'(pending_b), 32'(m_pend[3]));
            chk("model div_rdy_b", 32'(div_rdy_b), 32'(!m_pend[3]));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_pos(input int c, input int p, input string name);
        bit hit = 0;
        for (int n = 0; n < 16; n++) begin
            if (m_pos[c] == p) begin hit = 1; break; end
            step();
        end
        chk(name, 32'(hit), 32'd1);
    endtask

    initial begin
        bit found;
        rst = 1; sync = 0; en_a = '0; en_b = 0;
        div_wr = 0; div_ch = '0; div_val = '0;
        step(); step();
        chk("rst clk_out_a", 32'(clk_out_a), 32'd0);
        chk("rst tick_a", 32'(tick_a), 32'd0);
        chk("rst pending_a", 32'(pending_a), 32'd0);
        chk("rst clk_out_b", 32'(clk_out_b), 32'd0);

        // Default periods: D=4 on dut_a, D=5 on dut_b
        rst = 0; en_a = 3'b111; en_b = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("d4 clk", 32'(clk_out_a[0]), 32'((i % 4) < 2));
            chk("d4 tick", 32'(tick_a[0]), 32'((i % 4) == 0));
            chk("d5 clk", 32'(clk_out_b[0]), 32'((i % 5) < 2));
            chk("d5 tick", 32'(tick_b[0]), 32'((i % 5) == 0));
        end

        // Write D=6 to ch0 at cnt=1
        div_wr = 1; div_ch = 2'd0; div_val = 8'd6;
        #1 chk("wr6 rdy before", 32'(div_rdy_a), 32'd1);
        step();
        div_wr = 0;
        #1;
        chk("wr6 pending", 32'(pending_a[0]), 32'd1);
        chk("wr6 rdy after", 32'(div_rdy_a), 32'd0);
        step();
        chk("wr6 old period clk", 32'(clk_out_a[0]), 32'd0);
        chk("wr6 still pending", 32'(pending_a[0]), 32'd1);
        step();
        chk("wr6 apply tick", 32'(tick_a[0]), 32'd1);
        chk("wr6 apply clk", 32'(clk_out_a[0]), 32'd1);
        chk("wr6 pending clr", 32'(pending_a[0]), 32'd0);
        for (int j = 1; j < 6; j++) begin
            step();
            chk("d6 clk", 32'(clk_out_a[0]), 32'(j < 3));
            chk("d6 tick", 32'(tick_a[0]), 32'd0);
        end
        step();
        chk("d6 wrap tick", 32'(tick_a[0]), 32'd1);

        // div_val=0 clamps to D=2 on ch1
        div_wr = 1; div_ch = 2'd1; div_val = 8'd0;
        step();
        div_wr = 0;
        found = 0;
        for (int n = 0; n < 8; n++) begin
            step();
            if (!pending_a[1]) begin found = 1; break; end
        end
        chk("d2 applied", 32'(found), 32'd1);
        chk("d2 clk0", 32'(clk_out_a[1]), 32'd1);
        chk("d2 tick0", 32'(tick_a[1]), 32'd1);
        step();
        chk("d2 clk1", 32'(clk_out_a[1]), 32'd0);
        chk("d2 tick1", 32'(tick_a[1]), 32'd0);
        step();
        chk("d2 clk2", 32'(clk_out_a[1]), 32'd1);
        chk("d2 tick2", 32'(tick_a[1]), 32'd1);

        // Out-of-range channel is never accepted
        div_wr = 1; div_ch = 2'd3; div_val = 8'd7;
        #1 chk("oor rdy", 32'(div_rdy_a), 32'd0);
        step();
        div_wr = 0; div_ch = 2'd0;
        chk("oor pending", 32'(pending_a), 32'd0);

        // Write landing on the wrap edge of ch2 waits for the following wrap
        wait_pos(2, 3, "wait ch2 last slot");
        div_wr = 1; div_ch = 2'd2; div_val = 8'd3;
        step();
        div_wr = 0;
        chk("wrapwr pending", 32'(pending_a[2]), 32'd1);
        for (int j = 1; j <= 4; j++) begin
            step();
            chk("wrapwr pend seq", 32'(pending_a[2]), 32'(j < 4));
        end
        chk("wrapwr apply tick", 32'(tick_a[2]), 32'd1);

        // en[0] low for 3 cycles mid-period (ch0 D=6, pos 1)
        div_ch = 2'd0;
        wait_pos(0, 1, "wait ch0 pos1");
        en_a[0] = 0;
        for (int j = 0; j < 3; j++) begin
            step();
            chk("pause clk", 32'(clk_out_a[0]), 32'd1);
            chk("pause tick", 32'(tick_a[0]), 32'd0);
        end
        en_a[0] = 1;
        for (int j = 2; j <= 6; j++) begin
            step();
            chk("resume clk", 32'(clk_out_a[0]), 32'((j % 6) < 3));
            chk("resume tick", 32'(tick_a[0]), 32'(j == 6));
        end

        // Reset discards a pending divisor
        en_a[0] = 0;
        div_wr = 1; div_ch = 2'd0; div_val = 8'd9;
        #1 chk("rstp rdy", 32'(div_rdy_a), 32'd1);
        step();
        div_wr = 0;
        step(); step();
        chk("rstp pending held", 32'(pending_a[0]), 32'd1);
        chk("rstp rdy held", 32'(div_rdy_a), 32'd0);
        rst = 1;
        step();
        chk("rstp pending clr", 32'(pending_a), 32'd0);
        chk("rstp clk clr", 32'(clk_out_a), 32'd0);
        rst = 0; en_a = 3'b111;
        for (int j = 0; j < 5; j++) begin
            step();
            chk("post rst clk", 32'(clk_out_a[0]), 32'((j % 4) < 2));
            chk("post rst tick", 32'(tick_a[0]), 32'((j % 4) == 0));
        end

`ifdef CLK_DIV_SYNC_EN
        // ch0 D=4, ch1 D=6; sync at ch0 cnt=2 aligns both
        div_wr = 1; div_ch = 2'd1; div_val = 8'd6;
        step();
        div_wr = 0;
        found = 0;
        for (int n = 0; n < 8; n++) begin
            step();
            if (!pending_a[1]) begin found = 1; break; end
        end
        chk("sync d6 applied", 32'(found), 32'd1);
        wait_pos(0, 2, "wait ch0 pos2");
        sync = 1;
        step();
        sync = 0;
        chk("sync tick", 32'(tick_a[1:0]), 32'd3);
        chk("sync clk", 32'(clk_out_a[1:0]), 32'd3);
        step();
        chk("sync clk+1", 32'(clk_out_a[1:0]), 32'd3);
        step();
        chk("sync clk+2", 32'(clk_out_a[1:0]), 32'd2);
`endif

        step(); step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
